// File: rtl/ercm8_mul_sched_pkg.sv
// Shared definitions for the ERCM8 multiplier scheduler: default widths,
// the settle-counter width and the scheduler state encoding.
package ercm8_mul_sched_pkg;

  // Default operand width; the product is twice this and the mask is one less.
  localparam int DATA_W_DEF = 8;

  // Default number of cycles operands sit on the multiplier before sampling.
  localparam int SETTLE_CYCLES_DEF = 4;

  // Settle counter width; covers the full 1..255 settle range.
  localparam int CNT_W = 8;

  // Scheduler states. Encodings are fixed so waveforms stay readable
  // across revisions of the block.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Index of the requester to favour on a tie: whoever did not win last.
  function automatic logic tie_winner(input logic last_grant);
    return ~last_grant;
  endfunction

endpackage

// File: rtl/ercm8_mul_sched_rr_arb2.sv
// Two-way round-robin arbiter. Produces a one-hot grant among the valid
// requesters; on a tie the requester that did not win last time wins.
module rr_arb2
  import ercm8_mul_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Combinational grant selection.
  always_comb begin
    // NOTE: grant gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = tie_winner(last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ercm8_mul_sched.sv
// Scheduler that shares one ERCM8 approximate multiplier between two
// requesters. An accepted operation is parked on the multiplier inputs for
// SETTLE_CYCLES edges, the product is captured, and the response is held
// until the consumer takes it. Only one operation is in flight at a time.
module ercm8_mul_sched
  import ercm8_mul_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DATA_W        = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  input  logic [DATA_W-2:0]     req0_mask,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  input  logic [DATA_W-2:0]     req1_mask,

  output logic [DATA_W-1:0]     mul_a,
  output logic [DATA_W-1:0]     mul_b,
  output logic [DATA_W-2:0]     mul_mask,
  input  logic [2*DATA_W-1:0]   mul_p,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [2*DATA_W-1:0]   rsp_data,

  output logic                  busy
);

  // The counter is loaded with one less than the settle time so the
  // capture edge lands exactly SETTLE_CYCLES edges after the accept edge.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             op_id;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;
  logic             acc_id;
  logic             settle_done;

  assign idle        = (state == ST_IDLE);
  assign settle_done = (state == ST_SETTLE) && (cnt == '0);
  assign busy        = ~idle;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Readiness is only offered while idle; a grant already implies the
  // requester is valid, so any ready means an accept on this edge.
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = req0_ready | req1_ready;
  assign acc_id     = grant[1];

  // Control FSM: state, settle counter, owner id and fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_SETTLE;
            cnt        <= CNT_LOAD;
            op_id      <= acc_id;
            last_grant <= acc_id;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          // Return to idle only; acceptance waits for the next edge.
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Multiplier operand registers: loaded on accept, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these datapath registers are reset because their values are
      // visible on the ports and must read as zero after reset.
      mul_a    <= '0;
      mul_b    <= '0;
      mul_mask <= '0;
    end else if (accept) begin
      mul_a    <= acc_id ? req1_a    : req0_a;
      mul_b    <= acc_id ? req1_b    : req0_b;
      mul_mask <= acc_id ? req1_mask : req0_mask;
    end
  end

  // Response register: capture the product at the end of settling and
  // hold it until the consumer handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else if (settle_done) begin
      rsp_valid <= 1'b1;
      rsp_id    <= op_id;
      rsp_data  <= mul_p;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ercm8_mul_sched.sv
// Self-checking bench for ercm8_mul_sched. The multiplier is modelled as an
// exact product of the registered operands. A negedge monitor keeps a
// scoreboard of accepted operations; directed sequences check timing.
module tb_ercm8_mul_sched;

  localparam int S = 4;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  mask;
    logic [15:0] exp_p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [6:0]  req0_mask, req1_mask;
  logic [7:0]  mul_a, mul_b;
  logic [6:0]  mul_mask;
  logic [15:0] mul_p;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;

  logic        d1_req0_valid, d1_req0_ready, d1_req1_valid, d1_req1_ready;
  logic [7:0]  d1_req0_a, d1_req0_b, d1_req1_a, d1_req1_b;
  logic [6:0]  d1_req0_mask, d1_req1_mask;
  logic [7:0]  d1_mul_a, d1_mul_b;
  logic [6:0]  d1_mul_mask;
  logic [15:0] d1_mul_p;
  logic        d1_rsp_valid, d1_rsp_ready, d1_rsp_id, d1_busy;
  logic [15:0] d1_rsp_data;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign mul_p    = 16'(mul_a) * 16'(mul_b);
  assign d1_mul_p = 16'(d1_mul_a) * 16'(d1_mul_b);

  ercm8_mul_sched #(.SETTLE_CYCLES(S), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_mask(req0_mask),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_mask(req1_mask),
    .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  ercm8_mul_sched #(.SETTLE_CYCLES(1), .DATA_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(d1_req0_valid), .req0_ready(d1_req0_ready),
    .req0_a(d1_req0_a), .req0_b(d1_req0_b), .req0_mask(d1_req0_mask),
    .req1_valid(d1_req1_valid), .req1_ready(d1_req1_ready),
    .req1_a(d1_req1_a), .req1_b(d1_req1_b), .req1_mask(d1_req1_mask),
    .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_mask(d1_mul_mask), .mul_p(d1_mul_p),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_id(d1_rsp_id),
    .rsp_data(d1_rsp_data), .busy(d1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    return 16'(a) * 16'(b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until rsp_valid is seen; n is the number of edges taken.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < 40);
  endtask

  // Scoreboard: record accepts, compare on each response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) sb_q.push_back('{id: 1'b0, data: prod(req0_a, req0_b)});
      if (req1_valid && req1_ready) sb_q.push_back('{id: 1'b1, data: prod(req1_a, req1_b)});
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   seen;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  7'h00, 16'd143};
    vecs[1] = '{1'b1, 8'd255, 8'd255, 7'h7f, 16'd65025};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 7'h01, 16'd0};
    vecs[3] = '{1'b1, 8'd2,   8'd3,   7'h2a, 16'd6};
    vecs[4] = '{1'b0, 8'd128, 8'd2,   7'h40, 16'd256};
    vecs[5] = '{1'b1, 8'd1,   8'd255, 7'h13, 16'd255};

    rst = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_mask = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_mask = 0;
    rsp_ready = 1'b1;
    d1_req0_valid = 0; d1_req0_a = 0; d1_req0_b = 0; d1_req0_mask = 0;
    d1_req1_valid = 0; d1_req1_a = 0; d1_req1_b = 0; d1_req1_mask = 0;
    d1_rsp_ready = 1'b1;

    repeat (2) tick();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_mul_mask", 32'(mul_mask), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Single-requester operations, one per table row.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].id) begin
        req1_a = vecs[i].a; req1_b = vecs[i].b; req1_mask = vecs[i].mask; req1_valid = 1'b1;
      end else begin
        req0_a = vecs[i].a; req0_b = vecs[i].b; req0_mask = vecs[i].mask; req0_valid = 1'b1;
      end
      #1;
      check("vec_ready", 32'(vecs[i].id ? req1_ready : req0_ready), 1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("vec_busy", 32'(busy), 1);
      check("vec_mul_a", 32'(mul_a), 32'(vecs[i].a));
      check("vec_mul_b", 32'(mul_b), 32'(vecs[i].b));
      check("vec_mul_mask", 32'(mul_mask), 32'(vecs[i].mask));
      wait_rsp(lat);
      check("vec_latency", 32'(lat), S);
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
      check("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp_p));
      tick();
      check("vec_rsp_cleared", 32'(rsp_valid), 0);
      check("vec_idle", 32'(busy), 0);
    end

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    req0_a = 8'd255; req0_b = 8'd255; req0_valid = 1'b1;
    req1_a = 8'd2;   req1_b = 8'd3;   req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(lat);
      check("rr_period", 32'(lat), (k == 0) ? S + 1 : S + 2);
      check("rr_id", 32'(rsp_id), 32'(k % 2));
      check("rr_data", 32'(rsp_data), (k % 2) ? 32'd6 : 32'd65025);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("rr_idle", 32'(busy), 0);

    // Consumer stalls: response held, no grants, no accept on the release edge.
    rsp_ready = 1'b0;
    req0_a = 8'd7; req0_b = 8'd9; req0_valid = 1'b1;
    req1_a = 8'd4; req1_b = 8'd5; req1_valid = 1'b1;
    wait_rsp(lat);
    check("stall_latency", 32'(lat), S + 1);
    check("stall_id", 32'(rsp_id), 0);
    check("stall_data", 32'(rsp_data), 63);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_hold_data", 32'(rsp_data), 63);
      check("stall_hold_id", 32'(rsp_id), 0);
      check("stall_no_ready", 32'({req1_ready, req0_ready}), 0);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    tick();
    check("release_valid", 32'(rsp_valid), 0);
    check("release_no_accept", 32'(busy), 0);
    check("release_req1_ready", 32'(req1_ready), 1);
    wait_rsp(lat);
    req1_valid = 1'b0;
    check("release_latency", 32'(lat), S + 1);
    check("release_id", 32'(rsp_id), 1);
    check("release_data", 32'(rsp_data), 20);
    tick();

    // Operands change during SETTLE: registered copy must not follow.
    req0_a = 8'd10; req0_b = 8'd12; req0_mask = 7'h00; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req0_a = 8'd99;
    tick();
    tick();
    check("hold_mul_a", 32'(mul_a), 10);
    wait_rsp(lat);
    check("hold_latency", 32'(lat), S - 2);
    check("hold_data", 32'(rsp_data), 120);
    tick();

    // Reset mid-SETTLE discards the operation and restores tie priority.
    req0_a = 8'd3; req0_b = 8'd5; req0_mask = 7'h55; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check("arst_busy", 32'(busy), 0);
    check("arst_mul_a", 32'(mul_a), 0);
    check("arst_mul_b", 32'(mul_b), 0);
    check("arst_mul_mask", 32'(mul_mask), 0);
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_data", 32'(rsp_data), 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) seen++;
    end
    check("arst_no_rsp", 32'(seen), 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("arst_tie_req0", 32'(req0_ready), 1);
    check("arst_tie_req1", 32'(req1_ready), 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("withdraw_idle", 32'(busy), 0);

    // Minimum settle time on the second instance.
    d1_req0_a = 8'd200; d1_req0_b = 8'd100; d1_req0_valid = 1'b1;
    #1;
    check("s1_ready", 32'(d1_req0_ready), 1);
    tick();
    d1_req0_valid = 1'b0;
    check("s1_not_yet", 32'(d1_rsp_valid), 0);
    tick();
    check("s1_rsp_valid", 32'(d1_rsp_valid), 1);
    check("s1_rsp_data", 32'(d1_rsp_data), 20000);
    check("s1_rsp_id", 32'(d1_rsp_id), 0);
    tick();
    check("s1_idle", 32'(d1_busy), 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ercm8_mul_sched.md
ERCM8_MUL_SCHED -- requirements
Module: ercm8_mul_sched

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles operands are held stable on the multiplier before mul_p is sampled; legal range 1..255.
REQ-002 Parameter DATA_W, default 8: operand width; product width is 2*DATA_W; mask width is DATA_W-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-006 req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands.
REQ-008 req0_mask / req1_mask  input  DATA_W-1  approximation mask for that operation.
REQ-009 mul_a, mul_b  output  DATA_W  registered operands driven to the shared ERCM8_V2_4 instance.
REQ-010 mul_mask  output  DATA_W-1  registered mask driven to the multiplier.
REQ-011 mul_p  input  2*DATA_W  multiplier product (dat_o).
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index (0/1) that owns the response.
REQ-015 rsp_data  output  2*DATA_W  captured product.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, SETTLE, RESP.
REQ-018 IDLE: at most one of req0_ready/req1_ready is high, driven combinationally to the granted requester; both are low in SETTLE and RESP.
REQ-019 Arbitration: round-robin over valid requesters; the requester not granted last wins ties; a lone valid requester always wins.
REQ-020 Accept edge (granted valid and ready high): latch a/b/mask into mul_a/mul_b/mul_mask, latch the id, load the counter with SETTLE_CYCLES-1, update the last-grant pointer, go to SETTLE.
REQ-021 SETTLE: mul_a/mul_b/mul_mask stay constant; the counter decrements each edge while nonzero.
REQ-022 SETTLE exit: on the edge where the counter is 0, capture mul_p into rsp_data, set rsp_valid, and go to RESP.
REQ-023 Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
REQ-024 RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready is high on an edge; then rsp_valid clears and the FSM returns to IDLE.
REQ-025 No new acceptance occurs on the edge leaving RESP. Minimum period per operation is SETTLE_CYCLES+2 cycles.
REQ-026 mul_a/mul_b/mul_mask hold their last values in IDLE and RESP; they change only on accept edges.
REQ-027 req*_valid deasserting without acceptance is legal; no state change results.
REQ-028 rsp_ready in IDLE/SETTLE is ignored.

Reset
REQ-029 rst asynchronously forces: state IDLE, counter 0, rsp_valid 0, rsp_id 0, rsp_data 0, mul_a 0, mul_b 0, mul_mask 0, busy 0, last-grant pointer = 1, so requester 0 wins the first tie.
REQ-030 Reset during SETTLE or RESP discards the in-flight operation; no response is produced after release.

Structure
REQ-031 A shared package holds the state enum, DATA_W, the SETTLE_CYCLES default and the counter width (8).
REQ-032 Round-robin arbitration is one sub-module, rr_arb2 (inputs: valid[1:0], last_grant; output: grant[1:0]); the multiplier is instantiated outside this block.

Verification (bench ties mul_p to a behavioural exact model mul_a*mul_b; SETTLE_CYCLES=4)
REQ-033 req0 a=13 b=11 mask=0, rsp_ready=1 -> rsp_valid rises 4 edges after accept, rsp_id=0, rsp_data=143, busy low 1 cycle later.
REQ-034 req0 and req1 both valid continuously (0: 255x255, 1: 2x3) -> responses alternate id 0 (65025), 1 (6), 0, 1.
REQ-035 rsp_ready held low 10 cycles after rsp_valid -> rsp_data/rsp_id stable, req ready low throughout, no second accept until 1 edge after the handshake.
REQ-036 Operands changed on req0_a during SETTLE -> mul_a unchanged, rsp_data reflects the accepted operands.
REQ-037 rst pulsed mid-SETTLE -> all outputs 0 immediately, no rsp_valid afterward; next tie goes to requester 0.
REQ-038 SETTLE_CYCLES=1, a=200 b=100 -> rsp_valid 1 edge after accept, rsp_data=20000.
